// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: resets the mouse, enables streaming, then decodes
// 3-byte movement packets from a first-word-fall-through rx FIFO.
module ps2_mouse_ctrl #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_req,
    output logic       wr_ps2,
    output logic [7:0] ps2_tx_data,
    input  logic       ps2_tx_idle,
    output logic       rd_ps2_packet,
    input  logic [7:0] ps2_rx_data,
    input  logic       ps2_rx_buf_empty,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btn,
    output logic       m_done_tick,
    output logic       init_done,
    output logic       err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2,
        PKT1, PKT2, PKT3, DONE, ERR
    } state_t;

    state_t        state_q;
    logic [CW-1:0] to_cnt_q;
    logic [7:0]    b1_q, b2_q, tx_data_q;
    logic [8:0]    xm_q, ym_q;
    logic [2:0]    btn_q;
    logic          wr_q, tick_q, init_done_q, err_q;

    logic          pop, timed_out;
    logic [7:0]    exp_byte;
    state_t        wait_next;

    // The pop must be combinational: the FIFO head is consumed in the same
    // cycle it is sampled, otherwise the byte would be seen twice.
    always_comb begin
        pop = (state_q inside {WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2, PKT1, PKT2, PKT3})
              && !ps2_rx_buf_empty && !init_req;
        timed_out = (to_cnt_q == TO_LAST);
        exp_byte  = 8'hFA;
        wait_next = WAIT_BAT;
        case (state_q)
            WAIT_BAT:  begin exp_byte = 8'hAA; wait_next = WAIT_ID;  end
            WAIT_ID:   begin exp_byte = 8'h00; wait_next = SEND_EN;  end
            WAIT_ACK2: begin exp_byte = 8'hFA; wait_next = PKT1;     end
            default:   begin exp_byte = 8'hFA; wait_next = WAIT_BAT; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEND_RST;
            to_cnt_q    <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            tx_data_q   <= '0;
            xm_q        <= '0;
            ym_q        <= '0;
            btn_q       <= '0;
            wr_q        <= 1'b0;
            tick_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            tick_q <= 1'b0;
            if (init_req) begin
                state_q     <= SEND_RST;
                to_cnt_q    <= '0;
                init_done_q <= 1'b0;
                err_q       <= 1'b0;
            end else begin
                case (state_q)
                    SEND_RST, SEND_EN: begin
                        if (ps2_tx_idle) begin
                            wr_q      <= 1'b1;
                            tx_data_q <= (state_q == SEND_RST) ? 8'hFF : 8'hF4;
                            state_q   <= (state_q == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
                            to_cnt_q  <= '0;
                        end
                    end
                    WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
                        if (pop) begin
                            if (ps2_rx_data == exp_byte) begin
                                state_q  <= wait_next;
                                to_cnt_q <= '0;
                                if (state_q == WAIT_ACK2)
                                    init_done_q <= 1'b1;
                            end else begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end
                        end else if (timed_out) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    PKT1: begin
                        // Bit 3 is always set in a first packet byte; anything else is
                        // dropped so a lost byte cannot misalign every later packet.
                        if (pop && ps2_rx_data[3]) begin
                            b1_q    <= ps2_rx_data;
                            state_q <= PKT2;
                        end
                    end
                    PKT2: begin
                        if (pop) begin
                            b2_q    <= ps2_rx_data;
                            state_q <= PKT3;
                        end
                    end
                    PKT3: begin
                        if (pop) begin
                            xm_q    <= {b1_q[4], b2_q};
                            ym_q    <= {b1_q[5], ps2_rx_data};
                            btn_q   <= b1_q[2:0];
                            tick_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= PKT1;
                    ERR:     state_q <= ERR;
                    default: state_q <= SEND_RST;
                endcase
            end
        end
    end

    assign wr_ps2        = wr_q;
    assign ps2_tx_data   = tx_data_q;
    assign rd_ps2_packet = pop;
    assign xm            = xm_q;
    assign ym            = ym_q;
    assign btn           = btn_q;
    assign m_done_tick   = tick_q;
    assign init_done     = init_done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init handshake, packet decode, resync,
// error/timeout paths, tx back-pressure and asynchronous reset.
module tb_ps2_mouse_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       init_req;
    logic       wr_ps2;
    logic [7:0] ps2_tx_data;
    logic       ps2_tx_idle;
    logic       rd_ps2_packet;
    logic [7:0] ps2_rx_data;
    logic       ps2_rx_buf_empty;
    logic [8:0] xm, ym;
    logic [2:0] btn;
    logic       m_done_tick, init_done, err;

    ps2_mouse_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .init_req(init_req),
        .wr_ps2(wr_ps2), .ps2_tx_data(ps2_tx_data), .ps2_tx_idle(ps2_tx_idle),
        .rd_ps2_packet(rd_ps2_packet), .ps2_rx_data(ps2_rx_data),
        .ps2_rx_buf_empty(ps2_rx_buf_empty), .xm(xm), .ym(ym), .btn(btn),
        .m_done_tick(m_done_tick), .init_done(init_done), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    logic [7:0] wr_log[$];
    int n_checks = 0, n_pass = 0;
    int cyc = 0, pops = 0, ticks = 0, last_pop_cyc = -1, tick_cyc = -2, wr_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_rx();
        ps2_rx_buf_empty = (fifo.size() == 0);
        ps2_rx_data      = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive_rx();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        pops  = 0;
        ticks = 0;
    endtask

    function automatic logic [7:0] wr_at(input int k);
        return (wr_log.size() > k) ? wr_log[k] : 8'hxx;
    endfunction

    // One clock: the pop decision is taken mid-cycle, consequences are read #1 after the edge.
    task automatic step();
        logic r;
        @(negedge clk);
        r = rd_ps2_packet;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            void'(fifo.pop_front());
            pops++;
            last_pop_cyc = cyc;
        end
        drive_rx();
        if (wr_ps2) begin
            wr_log.push_back(ps2_tx_data);
            wr_cyc = cyc;
        end
        if (m_done_tick) begin
            ticks++;
            tick_cyc = cyc;
        end
    endtask

    initial begin
        reset = 1'b0;
        init_req = 1'b0;
        ps2_tx_idle = 1'b1;
        drive_rx();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", wr_ps2, 1'b0);
        check("rst_rd", rd_ps2_packet, 1'b0);
        check("rst_tick", m_done_tick, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_xm", xm, 9'h000);
        check("rst_ym", ym, 9'h000);
        check("rst_btn", btn, 3'b000);
        check("rst_tx_data", ps2_tx_data, 8'h00);

        // Normal init with all responses already queued
        reset = 1'b1;
        clear_logs();
        push(8'hFA); push(8'hAA); push(8'h00); push(8'hFA);
        for (int i = 0; i < 50 && !init_done; i++) step();
        repeat (3) step();
        check("init_wr_count", wr_log.size(), 2);
        check("init_cmd0", wr_at(0), 8'hFF);
        check("init_cmd1", wr_at(1), 8'hF4);
        check("init_pops", pops, 4);
        check("init_done", init_done, 1'b1);
        check("init_err", err, 1'b0);

        // 0x19 carries the X sign bit (bit4) but not the Y sign bit (bit5)
        clear_logs();
        push(8'h19); push(8'h05); push(8'hFE);
        for (int i = 0; i < 20 && ticks == 0; i++) step();
        check("pkt1_ticks", ticks, 1);
        check("pkt1_latency", tick_cyc, last_pop_cyc);
        check("pkt1_xm", xm, 9'h105);
        check("pkt1_ym", ym, 9'h0FE);
        check("pkt1_btn", btn, 3'b001);
        step();
        check("pkt1_tick_width", m_done_tick, 1'b0);

        // Y sign set, X sign clear: +5 / -2
        clear_logs();
        push(8'h29); push(8'h05); push(8'hFE);
        for (int i = 0; i < 20 && ticks == 0; i++) step();
        check("pkt2_ticks", ticks, 1);
        check("pkt2_latency", tick_cyc, last_pop_cyc);
        check("pkt2_xm", xm, 9'h005);
        check("pkt2_ym", ym, 9'h1FE);
        check("pkt2_btn", btn, 3'b001);

        // Resync: leading byte without bit3 is discarded
        clear_logs();
        push(8'h00); push(8'h08); push(8'h10); push(8'h20);
        for (int i = 0; i < 20 && ticks == 0; i++) step();
        check("resync_pops", pops, 4);
        check("resync_ticks", ticks, 1);
        check("resync_xm", xm, 9'h010);
        check("resync_ym", ym, 9'h020);
        check("resync_btn", btn, 3'b000);
        repeat (5) step();
        check("hold_xm", xm, 9'h010);
        check("hold_ticks", ticks, 1);

        // Bad ack -> ERR, which ignores further rx bytes and sends nothing
        clear_logs();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("initreq_clears_done", init_done, 1'b0);
        check("initreq_holds_xm", xm, 9'h010);
        push(8'hFE);
        for (int i = 0; i < 20 && !err; i++) step();
        check("bad_ack_err", err, 1'b1);
        push(8'h55);
        repeat (20) step();
        check("err_pops", pops, 1);
        check("err_wr_count", wr_log.size(), 1);
        check("err_hold", err, 1'b1);

        // Restart, then time out waiting for the first ack
        fifo.delete();
        drive_rx();
        clear_logs();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("restart_err_clr", err, 1'b0);
        for (int i = 0; i < 10 && wr_log.size() == 0; i++) step();
        check("restart_cmd", wr_at(0), 8'hFF);
        for (int i = 0; i < 200 && !err; i++) step();
        check("timeout_err", err, 1'b1);
        check("timeout_cycles", cyc - wr_cyc, 100);

        // Transmitter busy while in SEND_EN
        clear_logs();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < 10 && wr_log.size() == 0; i++) step();
        ps2_tx_idle = 1'b0;
        push(8'hFA); push(8'hAA); push(8'h00); push(8'hFA);
        repeat (50) step();
        check("busy_wr_count", wr_log.size(), 1);
        check("busy_pops", pops, 3);
        check("busy_init_done", init_done, 1'b0);
        ps2_tx_idle = 1'b1;
        for (int i = 0; i < 20 && !init_done; i++) step();
        check("busy_cmd1", wr_at(1), 8'hF4);
        check("busy_pops_done", pops, 4);
        check("busy_init_done_set", init_done, 1'b1);

        // Asynchronous reset while in PKT2 with a byte waiting
        clear_logs();
        push(8'h08);
        repeat (3) step();
        check("pkt2_pops", pops, 1);
        push(8'h10);
        reset = 1'b0;
        #1;
        check("arst_rd", rd_ps2_packet, 1'b0);
        check("arst_wr", wr_ps2, 1'b0);
        check("arst_tick", m_done_tick, 1'b0);
        check("arst_xm", xm, 9'h000);
        check("arst_ym", ym, 9'h000);
        check("arst_btn", btn, 3'b000);
        check("arst_init_done", init_done, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_tx_data", ps2_tx_data, 8'h00);

        // Init restarts by itself after reset release
        fifo.delete();
        drive_rx();
        clear_logs();
        reset = 1'b1;
        for (int i = 0; i < 10 && wr_log.size() == 0; i++) step();
        check("auto_start_cmd", wr_at(0), 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
